// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with flush/bubble/hold handling,
// context loopback and a hold watchdog. Define PIPE_PERF_CNT_EN for perf counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       CTX_W      = 66,
  parameter int unsigned       STALL_W    = 6,
  parameter int unsigned       STAGE      = 3,
  parameter logic [DATA_W-1:0] NOP_VAL    = '0,
  parameter int unsigned       HOLD_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [CTX_W-1:0]      ctx_i,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [CTX_W-1:0]      ctx_o,
  output logic [HOLD_CNT_W-1:0] hold_cycles,
  input  logic                  perf_clr,
  output logic [31:0]           perf_adv,
  output logic [31:0]           perf_bub,
  output logic [31:0]           perf_fls
);

  typedef enum logic [1:0] {ActFlush, ActBubble, ActAdvance, ActHold} action_e;

  localparam logic [HOLD_CNT_W-1:0] HoldMax = {HOLD_CNT_W{1'b1}};

  logic up, dn;
  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  action_e act;

  // Reset is handled in the register process; this decodes the remaining priorities.
  // The illegal up=0/dn=1 pattern falls through to ADVANCE.
  always_comb begin
    act = ActAdvance;
    if (flush)          act = ActFlush;
    else if (up && !dn) act = ActBubble;
    else if (up && dn)  act = ActHold;
  end

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [CTX_W-1:0]      ctx_q, ctx_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d, hold_inc;

  assign hold_inc = (hold_q == HoldMax) ? hold_q : hold_q + HOLD_CNT_W'(1);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctx_d   = '0;
    hold_d  = '0;
    unique case (act)
      ActFlush: begin
        valid_d = 1'b0;
        data_d  = NOP_VAL;
      end
      ActBubble: begin
        valid_d = 1'b0;
        data_d  = NOP_VAL;
        ctx_d   = ctx_i;
        hold_d  = hold_inc;
      end
      ActAdvance: begin
        valid_d = in_valid;
        data_d  = in_data;
      end
      ActHold: begin
        ctx_d  = ctx_i;
        hold_d = hold_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VAL;
      ctx_q   <= '0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctx_q   <= ctx_d;
      hold_q  <= hold_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign ctx_o       = ctx_q;
  assign hold_cycles = hold_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] adv_q, bub_q, fls_q;

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      adv_q <= '0;
      bub_q <= '0;
      fls_q <= '0;
    end else begin
      if (act == ActAdvance && in_valid && adv_q != '1) adv_q <= adv_q + 32'd1;
      if (act == ActBubble && bub_q != '1)              bub_q <= bub_q + 32'd1;
      if (act == ActFlush && fls_q != '1)               fls_q <= fls_q + 32'd1;
    end
  end

  assign perf_adv = adv_q;
  assign perf_bub = bub_q;
  assign perf_fls = fls_q;

  logic unused_stall;
  assign unused_stall = ^stall;
`else
  assign perf_adv = '0;
  assign perf_bub = '0;
  assign perf_fls = '0;

  logic unused_stall;
  assign unused_stall = ^{stall, perf_clr};
`endif

  // A downstream stall without an upstream stall breaks the pipeline contract.
  stall_order_a: assert property (@(posedge clk) disable iff (rst) !(!up && dn));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; a second instance with a
// 2-bit hold counter exercises saturation on the same stimulus.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, perf_clr;
  logic [5:0]  stall;
  logic [63:0] in_data;
  logic [65:0] ctx_i;

  logic        out_valid, out_valid2;
  logic [63:0] out_data, out_data2;
  logic [65:0] ctx_o, ctx_o2;
  logic [7:0]  hold_cycles;
  logic [1:0]  hold_cycles2;
  logic [31:0] perf_adv, perf_bub, perf_fls;
  logic [31:0] perf_adv2, perf_bub2, perf_fls2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_valid(in_valid),
    .in_data(in_data), .ctx_i(ctx_i), .out_valid(out_valid), .out_data(out_data),
    .ctx_o(ctx_o), .hold_cycles(hold_cycles), .perf_clr(perf_clr),
    .perf_adv(perf_adv), .perf_bub(perf_bub), .perf_fls(perf_fls)
  );

  pipe_stage_reg #(.HOLD_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_valid(in_valid),
    .in_data(in_data), .ctx_i(ctx_i), .out_valid(out_valid2), .out_data(out_data2),
    .ctx_o(ctx_o2), .hold_cycles(hold_cycles2), .perf_clr(perf_clr),
    .perf_adv(perf_adv2), .perf_bub(perf_bub2), .perf_fls(perf_fls2)
  );

`ifdef PIPE_PERF_CNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; perf_clr = 1'b0;
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF; stall = 6'b001000; ctx_i = 66'h9;

    // Reset
    step(); step();
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_data", 128'(out_data), 128'(0));
    check("rst_ctx", 128'(ctx_o), 128'(0));
    check("rst_hold", 128'(hold_cycles), 128'(0));
    check("rst_perf_bub", 128'(perf_bub), 128'(0));

    // Advance
    rst = 1'b0; stall = 6'b000000; in_valid = 1'b1; in_data = 64'h1234; ctx_i = 66'h99;
    step();
    check("adv_valid", 128'(out_valid), 128'(1));
    check("adv_data", 128'(out_data), 128'(64'h1234));
    check("adv_ctx", 128'(ctx_o), 128'(0));

    // Bubble with context loopback
    stall = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      ctx_i = 66'(5 + i);
      step();
      check("bub_valid", 128'(out_valid), 128'(0));
      check("bub_data", 128'(out_data), 128'(0));
      check("bub_ctx", 128'(ctx_o), 128'(5 + i));
      check("bub_hold", 128'(hold_cycles), 128'(i + 1));
    end
    // Release with in_valid=0: payload still follows in_data
    stall = 6'b000000; in_valid = 1'b0; in_data = 64'h77;
    step();
    check("rel_ctx", 128'(ctx_o), 128'(0));
    check("rel_hold", 128'(hold_cycles), 128'(0));
    check("rel_valid", 128'(out_valid), 128'(0));
    check("rel_data", 128'(out_data), 128'(64'h77));

    // Hold
    in_valid = 1'b1; in_data = 64'hAA;
    step();
    check("hold_pre_data", 128'(out_data), 128'(64'hAA));
    stall = 6'b011000; in_data = 64'hBB; in_valid = 1'b0;
    ctx_i = 66'h3_0000_0000_0000_0001;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_data", 128'(out_data), 128'(64'hAA));
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_cnt", 128'(hold_cycles), 128'(i + 1));
    end
    check("hold_ctx", 128'(ctx_o), 128'(66'h3_0000_0000_0000_0001));

    // Flush beats the stall pattern
    flush = 1'b1; in_valid = 1'b1;
    step();
    check("fls_valid", 128'(out_valid), 128'(0));
    check("fls_data", 128'(out_data), 128'(0));
    check("fls_ctx", 128'(ctx_o), 128'(0));
    check("fls_hold", 128'(hold_cycles), 128'(0));
    check("fls_perf", 128'(perf_fls), 128'(PerfOn ? 1 : 0));
    flush = 1'b0;

    // Saturation and perf counters, from a clean reset
    rst = 1'b1; stall = 6'b000000;
    step();
    rst = 1'b0; stall = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sat_hold2", 128'(hold_cycles2), 128'((i < 3) ? i + 1 : 3));
      check("sat_hold8", 128'(hold_cycles), 128'(i + 1));
    end
    check("sat_perf_bub", 128'(perf_bub2), 128'(PerfOn ? 5 : 0));
    check("sat_perf_fls", 128'(perf_fls2), 128'(0));

    // Clear wins over the simultaneous advance increment
    perf_clr = 1'b1; stall = 6'b000000; in_valid = 1'b1; in_data = 64'h55;
    step();
    check("clr_perf_bub", 128'(perf_bub2), 128'(0));
    check("clr_perf_adv", 128'(perf_adv2), 128'(0));
    check("clr_hold2", 128'(hold_cycles2), 128'(0));
    perf_clr = 1'b0;
    step();
    check("post_clr_adv", 128'(perf_adv2), 128'(PerfOn ? 1 : 0));
    check("post_clr_data", 128'(out_data2), 128'(64'h55));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the OpenMIPS-class core.
- Replaces hand-written per-stage latches (if/id, id/ex, ex/mem, mem/wb) with one block.
- Carries an opaque payload plus a valid bit, and handles reset, flush, bubble insertion and hold.
- Loops back multi-cycle execution context (e.g. partial multiply-accumulate result and cycle count) while the producing stage is stalled.
- Adds a hold-length watchdog counter, plus optional performance counters.

Parameters:
DATA_W, 64, payload width in bits (packed stage outputs)
CTX_W, 66, width of the multi-cycle context loopback channel
STALL_W, 6, width of the global stall vector
STAGE, 3, index of the upstream stage in the stall vector; downstream stage is STAGE+1 (STAGE+1 < STALL_W)
NOP_VAL, 0, payload value driven for reset, flush and bubbles (DATA_W bits)
HOLD_CNT_W, 8, width of the consecutive-hold counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high (1 = reset)
flush  in  1  pipeline flush (exception/eret), active-high
stall  in  STALL_W  global stall vector; bit = 1 means stop
in_valid  in  1  upstream slot holds a real instruction
in_data  in  DATA_W  upstream payload
ctx_i  in  CTX_W  context produced by the upstream stage this cycle
out_valid  out  1  registered valid toward the downstream stage
out_data  out  DATA_W  registered payload
ctx_o  out  CTX_W  context fed back to the upstream stage next cycle
hold_cycles  out  HOLD_CNT_W  consecutive cycles in the HOLD or BUBBLE state, saturating
perf_clr  in  1  clear performance counters (only used with PIPE_PERF_CNT_EN)
perf_adv  out  32  advance count
perf_bub  out  32  bubble count
perf_fls  out  32  flush count

Behaviour:
- Let up = stall[STAGE] and dn = stall[STAGE+1]. Actions are evaluated each rising edge in strict priority order:
  1. RESET (rst=1): out_valid=0, out_data=NOP_VAL, ctx_o=0, hold_cycles=0. Performance counters are cleared.
  2. FLUSH (flush=1): out_valid=0, out_data=NOP_VAL, ctx_o=0, hold_cycles=0. Flush wins over any stall pattern.
  3. BUBBLE (up=1, dn=0): out_valid=0, out_data=NOP_VAL, ctx_o<=ctx_i, hold_cycles saturating +1.
  4. ADVANCE (up=0): out_valid<=in_valid, out_data<=in_data, ctx_o=0, hold_cycles=0.
  5. HOLD (up=1, dn=1): out_valid and out_data unchanged, ctx_o<=ctx_i, hold_cycles saturating +1.
- Case up=0, dn=1 is illegal (a downstream stall must stall upstream). The block treats it as ADVANCE; with simulation assertions enabled it flags an error.
- Latency is 1 cycle from in_* to out_* on ADVANCE.
- Context contract: ctx_o is zero in every cycle following an ADVANCE, FLUSH or RESET. A stalled multi-cycle op therefore sees its own previous ctx_i exactly one cycle later.
- hold_cycles saturates at 2^HOLD_CNT_W-1 and never wraps.
- When an ADVANCE occurs with in_valid=0, out_valid=0 but out_data still takes in_data; the payload is not forced to NOP_VAL.
- Reset mid-hold: state is cleared regardless of stall; the next cycle behaves per the stall value at that time.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - perf_adv, perf_bub and perf_fls are 32-bit saturating counters incremented on ADVANCE with in_valid=1, on BUBBLE, and on FLUSH respectively.
  - perf_clr=1 zeroes all three synchronously. perf_clr has priority below rst and above increment; an increment in the same cycle is lost.
  - Counters are unaffected by the stall/flush priority except as counted events.
- Not defined: perf_* outputs are tied to 0, perf_clr is ignored, and no counter flops are instantiated.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xDEAD_BEEF, stall=6'b001000 → out_valid=0, out_data=0, ctx_o=0, hold_cycles=0.
- Advance: stall=0, in_valid=1, in_data=0x1234 → next cycle out_valid=1, out_data=0x1234, ctx_o=0.
- Bubble with loopback:
  - Stimulus: stall=6'b001000 (up=1, dn=0) for 3 cycles, ctx_i=0x5, 0x6, 0x7.
  - Response: out_valid=0 and out_data=NOP_VAL each cycle; ctx_o=0x5, 0x6, 0x7 one cycle later each; hold_cycles=1, 2, 3.
  - Then stall=0 → ctx_o=0, hold_cycles=0.
- Hold: after advancing 0xAA, drive stall=6'b011000 for 4 cycles → out_data stays 0xAA, out_valid stays 1, hold_cycles reaches 4.
- Flush priority: flush=1 together with stall=6'b011000 and in_valid=1 → out_valid=0, ctx_o=0, hold_cycles=0.
- Saturation and performance counters:
  - Setup: HOLD_CNT_W=2, PIPE_PERF_CNT_EN defined.
  - Stimulus: 5 cycles of BUBBLE.
  - Response: hold_cycles = 1, 2, 3, 3, 3 and perf_bub=5.
  - Then perf_clr=1 for 1 cycle → perf_bub=0.
